intersection_phase_scheduler: RTL and testbench

Sequences a two-road intersection: north-south (NS, main road) and east-west (EW, side road), with an exclusive pedestrian walk phase. Drives the red/yellow/green lamps for both roads plus walk/wait lamps from one Moore state machine and a shared tick-based phase timer. Adds side-road vehicle demand, latched pedestrian requests and emergency preemption. Sits above the per-lamp driver logic; `tick` comes from a system prescaler.

---
 rtl/intersection_phase_scheduler.sv | 153 +++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer with an exclusive pedestrian walk phase,
// side-road demand, latched pedestrian requests and emergency preemption.
module intersection_phase_scheduler #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 6,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       car_sense_ew,
  input  logic       emergency,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6,
    UNUSED    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TICKS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] timer;
  logic             ped_pending;
  logic             walk_from, walk_from_next;
  logic             expire;

  function automatic logic [CNT_W-1:0] load_value(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   load_value = GREEN_LOAD;
      NS_YELLOW, EW_YELLOW: load_value = YELLOW_LOAD;
      PED_WALK:             load_value = WALK_LOAD;
      default:              load_value = ALLRED_LOAD;
    endcase
  endfunction

  assign expire = tick && (timer == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ALL_RED_2;
      walk_from <= 1'b0;
    end else begin
      state     <= state_next;
      walk_from <= walk_from_next;
    end
  end

  // Emergency is tested before expiry everywhere so no green is entered under it.
  always_comb begin
    state_next     = state;
    walk_from_next = walk_from;
    case (state)
      NS_GREEN: begin
        if (emergency || (expire && (car_sense_ew || ped_pending)))
          state_next = NS_YELLOW;
      end
      NS_YELLOW: if (expire) state_next = ALL_RED_1;
      ALL_RED_1: begin
        if (expire && !emergency) begin
          if (ped_pending) begin
            state_next     = PED_WALK;
            walk_from_next = 1'b0;
          end else begin
            state_next = EW_GREEN;
          end
        end
      end
      EW_GREEN: if (emergency || expire) state_next = EW_YELLOW;
      EW_YELLOW: if (expire) state_next = ALL_RED_2;
      ALL_RED_2: begin
        if (expire && !emergency) begin
          if (ped_pending) begin
            state_next     = PED_WALK;
            walk_from_next = 1'b1;
          end else begin
            state_next = NS_GREEN;
          end
        end
      end
      PED_WALK: begin
        if (emergency)
          state_next = walk_from ? ALL_RED_2 : ALL_RED_1;
        else if (expire)
          state_next = walk_from ? NS_GREEN : EW_GREEN;
      end
      default: state_next = ALL_RED_2;
    endcase
  end

  // Timer reloads on any state change and otherwise saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      timer <= ALLRED_LOAD;
    else if (state_next != state)
      timer <= load_value(state_next);
    else if (tick && (timer != '0))
      timer <= timer - CNT_W'(1);
  end

  // Entering the walk phase clears the request even if the button is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ped_pending <= 1'b0;
    else if ((state_next == PED_WALK) && (state != PED_WALK))
      ped_pending <= 1'b0;
    else if (ped_req && (state != PED_WALK))
      ped_pending <= 1'b1;
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    case (state)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      PED_WALK:  walk = 1'b1;
      default:   ;
    endcase
  end

  assign ped_wait = ped_pending;
  assign phase    = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Randomised and directed bench for intersection_phase_scheduler, checked
// against a tick-elapsed reference model through an expected-value queue.
module tb_intersection_phase_scheduler;

  localparam int GREEN_TICKS  = 8;
  localparam int YELLOW_TICKS = 3;
  localparam int ALLRED_TICKS = 2;
  localparam int WALK_TICKS   = 6;
  localparam int W            = 11;

  logic       clk;
  logic       rst;
  logic       tick, ped_req, car_sense_ew, emergency;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk, ped_wait;
  logic [2:0] phase;
  logic [W-1:0] dut_vec;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rst_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;

  // Reference model: phase, ticks spent in the phase, pending request, walk origin
  int m_phase;
  int m_elapsed;
  bit m_pend;
  bit m_from;

  intersection_phase_scheduler #(
    .GREEN_TICKS(GREEN_TICKS), .YELLOW_TICKS(YELLOW_TICKS),
    .ALLRED_TICKS(ALLRED_TICKS), .WALK_TICKS(WALK_TICKS), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
    .car_sense_ew(car_sense_ew), .emergency(emergency),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_wait(ped_wait), .phase(phase)
  );

  assign dut_vec = {phase, ns_red, ns_yellow, ns_green,
                    ew_red, ew_yellow, ew_green, walk, ped_wait};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int dur(input int p);
    case (p)
      0, 3:    return GREEN_TICKS;
      1, 4:    return YELLOW_TICKS;
      6:       return WALK_TICKS;
      default: return ALLRED_TICKS;
    endcase
  endfunction

  // {red, yellow, green} for a road whose green phase is g and yellow is g+1
  function automatic logic [2:0] road(input int p, input int g);
    if (p == g) return 3'b001;
    if (p == g + 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [W-1:0] enc(input int p, input bit pend);
    logic [2:0] pc;
    pc = 3'(p);
    return {pc, road(p, 0), road(p, 3), (p == 6), pend};
  endfunction

  task automatic model_reset();
    m_phase   = 5;
    m_elapsed = 0;
    m_pend    = 1'b0;
    m_from    = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit p, input bit c, input bit e);
    int  nxt;
    bit  ex;
    nxt = m_phase;
    ex  = t && (m_elapsed + 1 >= dur(m_phase));
    case (m_phase)
      0: if (e || (ex && (c || m_pend))) nxt = 1;
      1: if (ex) nxt = 2;
      2: if (ex && !e) begin
           if (m_pend) begin nxt = 6; m_from = 1'b0; end else nxt = 3;
         end
      3: if (e || ex) nxt = 4;
      4: if (ex) nxt = 5;
      5: if (ex && !e) begin
           if (m_pend) begin nxt = 6; m_from = 1'b1; end else nxt = 0;
         end
      default: begin
        if (e) nxt = m_from ? 5 : 2;
        else if (ex) nxt = m_from ? 0 : 3;
      end
    endcase
    if (nxt == 6 && m_phase != 6) m_pend = 1'b0;
    else if (p && m_phase != 6) m_pend = 1'b1;
    if (nxt != m_phase) m_elapsed = 0;
    else if (t) m_elapsed = m_elapsed + 1;
    m_phase = nxt;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge.
  task automatic step(input bit t, input bit p, input bit c, input bit e);
    tick = t; ped_req = p; car_sense_ew = c; emergency = e;
    model_step(t, p, c, e);
    exp_q.push_back(enc(m_phase, m_pend));
    @(negedge clk);
  endtask

  task automatic run_until(input bit t, input bit c, input int tp, input int te,
                           input int max_steps);
    int n;
    n = 0;
    while (!(m_phase == tp && m_elapsed == te) && n < max_steps) begin
      step(t, 1'b0, c, 1'b0);
      n++;
    end
  endtask

  task automatic assert_reset();
    rst_q.push_back(enc(5, 1'b0));
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares after every rising edge, and shortly after reset assertion.
  always begin
    logic [W-1:0] e;
    @(posedge clk or negedge rst);
    #1;
    if (!rst) begin
      if (rst_q.size() > 0) begin
        e = rst_q.pop_front();
        n_cmp++;
        if (dut_vec !== e) begin
          n_fail++;
          $display("FAIL async_reset t=%0t: got %b want %b", $time, dut_vec, e);
        end
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_vec !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got phase=%0d vec=%b want phase=%0d vec=%b",
                 cycle, dut_vec[10:8], dut_vec, e[10:8], e);
      end
    end
  end

  initial begin
    bit emg;
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0; car_sense_ew = 1'b0; emergency = 1'b0;
    model_reset();
    #2;
    assert_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // No demand: two all-red ticks, then rest in NS green
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Constant side-road demand: full cycles
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Pedestrian pulse on the third cycle of a fresh NS green
    run_until(1'b1, 1'b1, 5, 0, 60);
    run_until(1'b1, 1'b0, 0, 2, 20);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Emergency on the fourth cycle of EW green, held 20 cycles
    run_until(1'b1, 1'b1, 3, 3, 80);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Slow tick: every fourth cycle
    for (int i = 0; i < 130; i++) step((i % 4) == 3, 1'b0, 1'b1, 1'b0);

    // Reset mid NS yellow with a pending request, between clock edges
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run_until(1'b1, 1'b1, 1, 0, 60);
    @(posedge clk);
    #3;
    assert_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic, requests, emergency bursts and tick rates
    emg = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) emg = ~emg;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, emg);
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
